// File: rtl/pet_pkg.sv
// Shared types and constants for the pet mood stage: mood codes, thresholds
// and the stat indices agreed with the upstream statistics block.
package pet_pkg;

  typedef enum logic [2:0] {
    MOOD_CONTENT = 3'd0,
    MOOD_HAPPY   = 3'd1,
    MOOD_SAD     = 3'd2,
    MOOD_SLEEPY  = 3'd3,
    MOOD_DIRTY   = 3'd4,
    MOOD_HUNGRY  = 3'd5,
    MOOD_SICK    = 3'd6,
    MOOD_DEAD    = 3'd7
  } mood_t;

  typedef logic [3:0] stat_t;

  localparam int NEED_TH     = 12;
  localparam int HYST        = 2;
  localparam int HAPPY_TH    = 4;
  localparam int DEATH_TICKS = 8;

  localparam int NUM_STATS      = 6;
  localparam int STAT_HUNGER    = 0;
  localparam int STAT_HAPPINESS = 1;
  localparam int STAT_HEALTH    = 2;
  localparam int STAT_HYGIENE   = 3;
  localparam int STAT_ENERGY    = 4;
  localparam int STAT_SOCIAL    = 5;

  // Moods that demand the owner's attention and raise the alert on entry.
  function automatic logic is_urgent(mood_t m);
    return (m == MOOD_SICK) || (m == MOOD_HUNGRY) || (m == MOOD_DIRTY);
  endfunction

endpackage

// File: rtl/pet_mood_if.sv
// Bundle between the stats stage (master), the mood stage (slave) and the
// display logic that consumes mood/alert/alive/age.
interface pet_mood_if;
  logic       tick;
  logic       ack;
  logic [3:0] hunger;
  logic [3:0] happiness;
  logic [3:0] health;
  logic [3:0] hygiene;
  logic [3:0] energy;
  logic [3:0] social;
  logic [2:0] mood;
  logic       alert;
  logic       alive;
  logic [7:0] age;

  modport master (
    output tick, ack, hunger, happiness, health, hygiene, energy, social,
    input  mood, alert, alive, age
  );

  modport slave (
    input  tick, ack, hunger, happiness, health, hygiene, energy, social,
    output mood, alert, alive, age
  );
endinterface

// File: rtl/need_hyst.sv
// Per-stat need flag with hysteresis. The output is the value the flag holds
// after this cycle, so the mood resolver sees the updated flag on the same tick.
module need_hyst #(
  parameter int NEED_TH = pet_pkg::NEED_TH,
  parameter int HYST    = pet_pkg::HYST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] stat,
  output logic       need
);

  localparam logic [3:0] SET_LVL = 4'(NEED_TH);
  localparam logic [3:0] CLR_LVL = 4'(NEED_TH - HYST);

  logic flag_q;

  always_comb begin
    // NOTE: default assignment first so every path drives need; no latch is inferred.
    need = flag_q;
    if (tick) begin
      if (stat >= SET_LVL)     need = 1'b1;
      else if (stat < CLR_LVL) need = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) flag_q <= 1'b0;
    else        flag_q <= need;
  end

endmodule

// File: rtl/pet_mood.sv
// Pet mood resolver: hysteresis need flags, prioritized mood, latched alert and age.
// Define PET_DEATH_EN to build the sickness death counter and the DEAD state.
module pet_mood
  import pet_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  pet_mood_if.slave bus
);

  localparam stat_t HAPPY_LVL = 4'(HAPPY_TH);

  stat_t              stats [NUM_STATS];
  logic [NUM_STATS-1:0] need;
  logic               live_tick;
  logic               dead_q;
  logic               dead_next;
  logic               all_low;
  logic               set_alert;
  mood_t              cand;
  mood_t              mood_q;
  logic               alert_q;
  logic [7:0]         age_q;

  assign stats[STAT_HUNGER]    = bus.hunger;
  assign stats[STAT_HAPPINESS] = bus.happiness;
  assign stats[STAT_HEALTH]    = bus.health;
  assign stats[STAT_HYGIENE]   = bus.hygiene;
  assign stats[STAT_ENERGY]    = bus.energy;
  assign stats[STAT_SOCIAL]    = bus.social;

  // A dead pet ignores ticks entirely, which freezes flags and counters.
  assign live_tick = bus.tick & ~dead_q;

  for (genvar i = 0; i < NUM_STATS; i++) begin : g_need
    need_hyst #(.NEED_TH(NEED_TH), .HYST(HYST)) u_need (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (live_tick),
      .stat  (stats[i]),
      .need  (need[i])
    );
  end

  always_comb begin
    all_low = 1'b1;
    for (int i = 0; i < NUM_STATS; i++) begin
      if (stats[i] > HAPPY_LVL) all_low = 1'b0;
    end
  end

  always_comb begin
    cand = MOOD_CONTENT;
    if (need[STAT_HEALTH])                            cand = MOOD_SICK;
    else if (need[STAT_HUNGER])                       cand = MOOD_HUNGRY;
    else if (need[STAT_HYGIENE])                      cand = MOOD_DIRTY;
    else if (need[STAT_ENERGY])                       cand = MOOD_SLEEPY;
    else if (need[STAT_HAPPINESS] || need[STAT_SOCIAL]) cand = MOOD_SAD;
    else if (all_low)                                 cand = MOOD_HAPPY;
  end

`ifdef PET_DEATH_EN
  localparam int            CW      = $clog2(DEATH_TICKS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEATH_TICKS);

  logic [CW-1:0] sick_cnt_q;
  logic [CW-1:0] sick_cnt_next;

  always_comb begin
    sick_cnt_next = sick_cnt_q;
    if (live_tick) begin
      if (bus.health != 4'hF)       sick_cnt_next = '0;
      else if (sick_cnt_q != CNT_MAX) sick_cnt_next = sick_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sick_cnt_q <= '0;
    else        sick_cnt_q <= sick_cnt_next;
  end

  assign dead_next = (sick_cnt_next == CNT_MAX);
`else
  assign dead_next = 1'b0;
`endif

  // Entering any urgent mood, including from another urgent one, raises the alert.
  assign set_alert = live_tick && !dead_next && is_urgent(cand) && (cand != mood_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mood_q  <= MOOD_CONTENT;
      alert_q <= 1'b0;
      age_q   <= 8'd0;
      dead_q  <= 1'b0;
    end else if (!dead_q) begin
      if (bus.tick) begin
        mood_q <= dead_next ? MOOD_DEAD : cand;
        dead_q <= dead_next;
        if (age_q != 8'hFF) age_q <= age_q + 8'd1;
      end
      if (set_alert)    alert_q <= 1'b1;
      else if (bus.ack) alert_q <= 1'b0;
    end
  end

  assign bus.mood  = mood_q;
  assign bus.alert = alert_q;
  assign bus.alive = ~dead_q;
  assign bus.age   = age_q;

endmodule

// File: tb/tb_pet_mood.sv
// Self-checking bench for pet_mood: directed scenarios with literal expectations
// plus randomized stimulus compared every cycle against a behavioural model.
module tb_pet_mood;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  bit   cmp_en = 1'b0;

  pet_mood_if bus();

  pet_mood dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mood priority equals the numeric mood code, so the mood is the largest
  // code among the raised needs (HAPPY/CONTENT when none are raised).
  int  stat_mood [6] = '{5, 2, 6, 4, 3, 2};
  bit  m_flag [6];
  int  m_mood, m_age;
  bit  m_alert, m_dead;
`ifdef PET_DEATH_EN
  int  m_cnt;
`endif

  always @(posedge clk) begin
    int  s [6];
    int  newm;
    bit  died, setal, anyflag, low;
    s = '{int'(bus.hunger), int'(bus.happiness), int'(bus.health),
          int'(bus.hygiene), int'(bus.energy), int'(bus.social)};
    if (!rst_n) begin
      foreach (m_flag[i]) m_flag[i] = 1'b0;
      m_mood = 0; m_age = 0; m_alert = 1'b0; m_dead = 1'b0;
`ifdef PET_DEATH_EN
      m_cnt = 0;
`endif
    end else if (!m_dead) begin
      if (bus.tick) begin
        for (int i = 0; i < 6; i++) begin
          if (s[i] >= 12)     m_flag[i] = 1'b1;
          else if (s[i] < 10) m_flag[i] = 1'b0;
        end
        newm = 0; anyflag = 1'b0; low = 1'b1;
        for (int i = 0; i < 6; i++) begin
          if (m_flag[i]) begin
            anyflag = 1'b1;
            if (stat_mood[i] > newm) newm = stat_mood[i];
          end
          if (s[i] > 4) low = 1'b0;
        end
        if (!anyflag && low) newm = 1;
        died = 1'b0;
`ifdef PET_DEATH_EN
        if (s[2] == 15) m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
        else            m_cnt = 0;
        died = (m_cnt == 8);
`endif
        if (died) newm = 7;
        setal = (newm >= 4 && newm <= 6) && (newm != m_mood);
        if (setal)        m_alert = 1'b1;
        else if (bus.ack) m_alert = 1'b0;
        m_mood = newm;
        if (m_age < 255) m_age++;
        m_dead = died;
      end else if (bus.ack) begin
        m_alert = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_mood",  bus.mood,  m_mood);
      check("model_alert", bus.alert, m_alert);
      check("model_alive", bus.alive, !m_dead);
      check("model_age",   bus.age,   m_age);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_stats(input logic [3:0] hu, ha, he, hy, en, so);
    bus.hunger = hu; bus.happiness = ha; bus.health = he;
    bus.hygiene = hy; bus.energy = en; bus.social = so;
  endtask

  task automatic step(input logic t, input logic a);
    bus.tick = t; bus.ack = a;
    @(posedge clk); #1;
    bus.tick = 1'b0; bus.ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b1, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic expect_out(input string tag, input int mood, input int alert,
                            input int alive, input int age);
    check({tag, "_mood"},  bus.mood,  mood);
    check({tag, "_alert"}, bus.alert, alert);
    check({tag, "_alive"}, bus.alive, alive);
    check({tag, "_age"},   bus.age,   age);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hmode, calm;
    rst_n = 1'b0;
    bus.tick = 1'b0; bus.ack = 1'b0;
    set_stats(0, 0, 0, 0, 0, 0);
    do_reset();
    cmp_en = 1'b1;
    expect_out("reset", 0, 0, 1, 0);

    // Basic tick, hunger hysteresis and ack.
    step(1'b1, 1'b0);
    expect_out("first_tick", 1, 0, 1, 1);
    set_stats(12, 0, 0, 0, 0, 0); step(1'b1, 1'b0);
    expect_out("hunger12", 5, 1, 1, 2);
    set_stats(10, 0, 0, 0, 0, 0); step(1'b1, 1'b0);
    check("hunger10_hold", bus.mood, 5);
    set_stats(9, 0, 0, 0, 0, 0); step(1'b1, 1'b0);
    expect_out("hunger9", 0, 1, 1, 4);
    step(1'b0, 1'b1);
    check("ack_clears", bus.alert, 0);

    // Health beats hunger; ack coinciding with HUNGRY->SICK keeps alert.
    set_stats(13, 0, 13, 0, 0, 0); step(1'b1, 1'b0);
    expect_out("sick_over_hungry", 6, 1, 1, 5);
    step(1'b0, 1'b1);
    set_stats(13, 0, 0, 0, 0, 0); step(1'b1, 1'b0);
    expect_out("sick_to_hungry", 5, 1, 1, 6);
    step(1'b0, 1'b1);
    set_stats(13, 0, 13, 0, 0, 0); step(1'b1, 1'b1);
    expect_out("set_wins_ack", 6, 1, 1, 7);

    // Stats changing between ticks do nothing.
    do_reset();
    set_stats(0, 0, 0, 0, 0, 0); step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_stats(15, 15, 15, 15, 15, 15); step(1'b0, 1'b0);
    end
    expect_out("no_tick_hold", 1, 0, 1, 1);

    // Prolonged maximum sickness.
    do_reset();
    set_stats(0, 0, 15, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    expect_out("sick7", 6, 1, 1, 7);
    step(1'b1, 1'b0);
`ifdef PET_DEATH_EN
    expect_out("dead8", 7, 1, 0, 8);
    set_stats(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    expect_out("dead_frozen", 7, 1, 0, 8);
`else
    expect_out("nodeath8", 6, 1, 1, 8);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    expect_out("nodeath20", 6, 1, 1, 20);
`endif

    // Counter restarts when health dips to 14.
    do_reset();
    set_stats(0, 0, 15, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    set_stats(0, 0, 14, 0, 0, 0); step(1'b1, 1'b0);
    set_stats(0, 0, 15, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    expect_out("restart7", 6, 1, 1, 12);
    step(1'b1, 1'b0);
`ifdef PET_DEATH_EN
    expect_out("restart8", 7, 1, 0, 13);
`else
    expect_out("restart8", 6, 1, 1, 13);
`endif

    // Age saturation.
    do_reset();
    set_stats(5, 5, 5, 5, 5, 5);
    bus.tick = 1'b1;
    repeat (300) @(posedge clk);
    #1 bus.tick = 1'b0;
    expect_out("age_sat", 0, 0, 1, 255);

    // Randomized run with sticky sickness and calm phases.
    hmode = 1'b0; calm = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) hmode = ~hmode;
      if ($urandom_range(0, 29) == 0) calm = ~calm;
      rst_n = ($urandom_range(0, 249) != 0);
      if (calm)
        set_stats(4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                  4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)));
      else
        set_stats(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if (hmode) bus.health = 4'hF;
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 6) == 0));
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pet_mood.md
# pet_mood

Mood/condition stage directly downstream of the pet statistics block. Samples the six 4-bit need statistics (hunger, happiness, health, hygiene, energy, social) on a time-base strobe. Applies per-stat hysteresis and resolves a single prioritized mood for the display/sprite logic. Also tracks pet age, raises a latched alert for urgent needs, and declares death after prolonged maximum sickness. Convention: a higher stat value means a greater unmet need; 15 is the worst.

## Interface
- NEED_TH, 12: a need flag sets when its stat is at or above this value.
- HYST, 2: a need flag clears when its stat is below NEED_TH-HYST.
- HAPPY_TH, 4: HAPPY requires every stat to be at or below this value.
- DEATH_TICKS, 8: number of consecutive ticks with health==15 that causes DEAD.
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- tick  in  1  one-cycle time-base strobe; all state updates occur only when tick=1.
- hunger, happiness, health, hygiene, energy, social  in  4 each  need levels from the stats stage.
- ack  in  1  user acknowledge; clears alert.
- mood  out  3  registered mood code.
- alert  out  1  latched urgent-need indication.
- alive  out  1  0 once DEAD is reached.
- age  out  8  tick count since reset; saturates.

## Operation
- Mood codes: 0 CONTENT, 1 HAPPY, 2 SAD, 3 SLEEPY, 4 DIRTY, 5 HUNGRY, 6 SICK, 7 DEAD.
- Need flags, one per stat, updated on tick:
  - set when stat >= NEED_TH;
  - clear when stat < NEED_TH-HYST;
  - otherwise hold.
- Flag to mood mapping: health→SICK, hunger→HUNGRY, hygiene→DIRTY, energy→SLEEPY, happiness or social→SAD.
- Candidate mood priority: DEAD > SICK > HUNGRY > DIRTY > SLEEPY > SAD > HAPPY > CONTENT.
  - HAPPY requires no flag set and all six stats <= HAPPY_TH.
  - CONTENT is the fallback.
- The candidate uses the flag values being written on the same tick (next-state flags).
- Death counter:
  - on tick, if health==15, increment (saturating at DEATH_TICKS);
  - on tick, if health!=15, clear to 0;
  - when it reaches DEATH_TICKS, mood becomes DEAD.
  - DEAD is absorbing until rst_n=0: flags, age and alert freeze, and ack is ignored.
- Alert:
  - sets when mood transitions into SICK, HUNGRY or DIRTY from any other code;
  - clears on ack;
  - if ack coincides with a setting transition, alert stays 1 (set wins);
  - a transition between two urgent moods (e.g. HUNGRY→SICK) also sets it.
- Age: +1 per tick while alive, saturating at 255.
- Reset values: mood=CONTENT(0), alert=0, alive=1, age=0, all flags=0, death counter=0.

## Timing
- All outputs are registered.
- A tick sampled at cycle N updates mood/alert/age/alive, which are visible at N+1.
- Stats are sampled only in tick cycles; stat changes between ticks have no effect.
- ack acts in any cycle, tick or not; alert=0 is visible in the next cycle.
- rst_n=0 overrides tick and ack in the same cycle. Reset mid-countdown clears the death counter.
- Back-to-back ticks (tick held high) are legal; each cycle counts as one tick.

## Configuration
- PET_DEATH_EN defined: death counter, DEAD state and alive=0 behave as above.
- PET_DEATH_EN undefined:
  - no death counter is built;
  - mood never reaches 7 and alive is tied to 1;
  - health==15 keeps producing SICK indefinitely.

## Structure
- Shared package pet_pkg holds:
  - mood_t enum with the eight codes above;
  - default threshold constants (NEED_TH, HYST, HAPPY_TH, DEATH_TICKS);
  - the stat-index constants shared with the stats stage.
- Sub-module need_hyst: one 4-bit stat in, tick, reset, one hysteresis flag out, with NEED_TH/HYST parameters. Instantiated six times.
- Priority resolution, alert, age and death logic live in pet_mood.

## Test plan
- Reset, all stats 0, one tick → mood=HAPPY(1), age=1, alert=0, alive=1.
- Hunger 12 on tick → mood=HUNGRY(5) and alert=1. Hunger 10 on next tick → still HUNGRY (hysteresis). Hunger 9 → mood=CONTENT or HAPPY per the other stats; alert stays 1 until ack.
- Hunger=13 and health=13 together on one tick → mood=SICK(6). ack pulsed in the same cycle as a new HUNGRY→SICK transition → alert remains 1.
- Health=15 for 8 consecutive ticks → mood=DEAD(7), alive=0 at cycle after 8th tick. Health drops to 0 afterwards → stays DEAD, age frozen.
  - Repeat with health=14 on the 5th tick → counter restarts, no death.
- 300 ticks with all stats 5 → age saturates at 255, mood=CONTENT(0).
- PET_DEATH_EN undefined, health=15 for 20 ticks → mood=SICK(6), alive=1. Stats changing between ticks with tick=0 → no output change.
